ltpi_smbus_event_detector: RTL and testbench
============================================

// Module: ltpi_smbus_event_detector
// PURPOSE
// - Front end of the LTPI SMBus relay: samples raw SCL/SDA, synchronises and deglitches them, decodes
//   bus events (START, STOP, data bits, SCL-low timeout) and queues them for the LTPI frame packer.
// - The downstream relay consumes events through a valid/ready FIFO port.
// - Exercised by the ltpi_smbus SVUnit suite.
// PARAMETERS
// - FILTER_LEN   3      cycles the synchronised input must be stable before the filtered value changes
// - FIFO_DEPTH   8      event queue depth; power of 2, >= 2
// - TIMEOUT_CYC  25000  SCL-low cycles while busy before TIMEOUT is declared; counter width $clog2(TIMEOUT_CYC+1)
// PORTS
// - clk           in   1  block clock
// - reset_n       in   1  asynchronous, active-low reset
// - enable        in   1  0: FSM held in IDLE, no pushes; the FIFO stays drainable
// - scl_i         in   1  raw SCL pin (asynchronous)
// - sda_i         in   1  raw SDA pin (asynchronous)
// - evt_valid     out  1  FIFO head holds an event
// - evt_code      out  3  smbus_evt_t of the head entry
// - evt_ready     in   1  consumer accepts head when evt_valid & evt_ready
// - bus_busy      out  1  FSM in BUSY
// - timeout_pulse out  1  one-cycle pulse when TIMEOUT is declared
// - overflow      out  1  sticky: an event was dropped because the FIFO was full
// - overflow_clr  in   1  clears overflow
// BEHAVIOUR
// - Reset values:
//   - sync flops and filtered SCL/SDA = 1; FSM IDLE; FIFO empty
//   - evt_valid=0, evt_code=EVT_NONE, bus_busy=0, timeout_pulse=0, overflow=0
// - Sync and filter:
//   - 2-flop synchroniser per pin.
//   - The filter counter resets whenever the synchronised value differs from its previous sample.
//   - The filtered output takes the new value once that value has been held FILTER_LEN consecutive cycles.
// - Edge detect: compare filtered values against their one-cycle-delayed copies.
// - START: SDA falls while SCL is stable high.
//   - Legal in IDLE and in BUSY (repeated start); push EVT_START; next state BUSY.
// - STOP: SDA rises while SCL is stable high.
//   - In BUSY: push EVT_STOP; next state IDLE.
//   - In IDLE: ignored.
// - Data bits (BUSY only):
//   - Latch SDA on the SCL rising edge.
//   - On the next SCL falling edge, push EVT_DATA0 or EVT_DATA1.
//   - If START or STOP occurred during that high phase, drop the latched bit and push nothing.
// - Simultaneous SCL and SDA edges in the same cycle: treat as an SCL edge only; the SDA change is neither START nor STOP.
// - Timeout:
//   - In BUSY, count cycles with filtered SCL=0; the count resets on SCL high or on leaving BUSY.
//   - When the count reaches TIMEOUT_CYC: push EVT_TIMEOUT, pulse timeout_pulse, go to IDLE.
// - Latency:
//   - An event decoded in cycle N is written to the FIFO at the end of N.
//   - It is visible at the head with evt_valid=1 in cycle N+1 if the FIFO was empty.
//   - Raw pin to filtered edge: 2 + FILTER_LEN cycles.
// - FIFO:
//   - A push is accepted when not full, or when a pop happens in the same cycle.
//   - Otherwise the event is dropped and overflow is set.
//   - Push and pop in the same cycle on an empty FIFO: the entry is written and the pop is ignored (evt_valid was 0).
//   - Pointers wrap modulo FIFO_DEPTH; the count has one extra bit.
//   - At most one event is decoded per cycle.
// - overflow: a set condition and overflow_clr in the same cycle leave it set.
// - enable=0:
//   - FSM forced to IDLE; timeout counter and latched bit cleared; no pushes.
//   - Synchronisers and filters keep running.
//   - On re-enable, the first event reported is a START.
// - reset_n asserted mid-transfer: everything returns to reset values immediately, and queued events are lost.
// STRUCTURE
// - ltpi_smbus_pkg holds:
//   - typedef enum logic [2:0] smbus_evt_t: EVT_NONE=0, EVT_START=1, EVT_STOP=2, EVT_DATA0=3, EVT_DATA1=4, EVT_TIMEOUT=5
//   - typedef enum logic bus_state_t: IDLE, BUSY
// - Sub-module ltpi_smbus_glitch_filter (sync + filter, parameter FILTER_LEN), instantiated once per pin.
// - The FIFO stays inline.
// TESTING
// - Write of 0xA5 with ACK, evt_ready=1 ->
//   START, 8 DATA bits 1,0,1,0,0,1,0,1, DATA0 for the ACK, STOP; bus_busy 1 then 0.
// - Repeated start: START, 3 bits, START, STOP ->
//   the second START is reported; the bit interrupted by it is not.
// - SDA glitch of FILTER_LEN-1 cycles while SCL is high ->
//   no event, bus_busy unchanged.
// - SCL held low for TIMEOUT_CYC cycles after START ->
//   EVT_TIMEOUT; timeout_pulse high for exactly 1 cycle; bus_busy=0.
// - evt_ready=0, generate 10 events with FIFO_DEPTH=8 ->
//   8 events queued in order, overflow=1; overflow_clr clears it; drain yields the first 8.
// - reset_n pulsed low mid-byte with 3 events queued ->
//   evt_valid=0, bus_busy=0 immediately.
// - reset_n pulsed low mid-byte, then bus traffic resumes ->
//   no events until the next START.

Source files
------------

// File: rtl/ltpi_smbus_pkg.sv
// Shared types for the LTPI SMBus relay front end.
// Event codes queued for the frame packer and the bus state.
package ltpi_smbus_pkg;

  typedef enum logic [2:0] {
    EVT_NONE    = 3'd0,
    EVT_START   = 3'd1,
    EVT_STOP    = 3'd2,
    EVT_DATA0   = 3'd3,
    EVT_DATA1   = 3'd4,
    EVT_TIMEOUT = 3'd5
  } smbus_evt_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_t;

  function automatic smbus_evt_t data_evt(input logic b);
    return b ? EVT_DATA1 : EVT_DATA0;
  endfunction

endpackage

// File: rtl/ltpi_smbus_glitch_filter.sv
// Two-flop synchroniser plus stability filter for one SMBus pin.
// The output follows the pin once it has held FILTER_LEN cycles.
module ltpi_smbus_glitch_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic filt
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN);

  logic s1;
  logic s2;
  logic s_prev;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // cnt = consecutive cycles the synchronised value has been held
  always_comb begin
    cnt_nxt = cnt;
    if (s2 != s_prev) begin
      cnt_nxt = CW'(1);
    end else if (cnt < CMAX) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s_prev <= 1'b1;
      filt   <= 1'b1;
      cnt    <= CMAX;
    end else begin
      s1     <= pin;
      s2     <= s1;
      s_prev <= s2;
      cnt    <= cnt_nxt;
      if (cnt_nxt == CMAX) begin
        filt <= s2;
      end
    end
  end

endmodule

// File: rtl/ltpi_smbus_event_detector.sv
// SMBus event decoder: filters SCL/SDA, decodes START/STOP/data/timeout
// and queues the events for the LTPI frame packer.
module ltpi_smbus_event_detector
  import ltpi_smbus_pkg::*;
#(
  parameter int FILTER_LEN  = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       evt_valid,
  output smbus_evt_t evt_code,
  input  logic       evt_ready,
  output logic       bus_busy,
  output logic       timeout_pulse,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic scl_f;
  logic sda_f;
  logic scl_d;
  logic sda_d;

  ltpi_smbus_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (scl_i),
    .filt    (scl_f)
  );

  ltpi_smbus_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (sda_i),
    .filt    (sda_f)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic scl_hi;
  logic start;
  logic stop;

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  // An SCL edge in the same cycle makes scl_hi false, masking SDA.
  assign scl_hi   = scl_f & scl_d;
  assign start    = ~sda_f & sda_d & scl_hi;
  assign stop     = sda_f & ~sda_d & scl_hi;

  bus_state_t state;
  bus_state_t state_nxt;
  logic       bit_valid;
  logic       bit_val;
  logic [TW-1:0] tcnt;
  logic       push;
  smbus_evt_t push_code;
  logic       tmo;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_code = EVT_NONE;
    tmo       = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else if (start) begin
      push      = 1'b1;
      push_code = EVT_START;
      state_nxt = BUSY;
    end else if (state == BUSY) begin
      if (stop) begin
        push      = 1'b1;
        push_code = EVT_STOP;
        state_nxt = IDLE;
      end else if (scl_fall && bit_valid) begin
        push      = 1'b1;
        push_code = data_evt(bit_val);
      end else if (!scl_f && tcnt == TLAST) begin
        push      = 1'b1;
        push_code = EVT_TIMEOUT;
        tmo       = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_valid     <= 1'b0;
      bit_val       <= 1'b0;
      tcnt          <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      timeout_pulse <= tmo;
      if (state != BUSY || state_nxt != BUSY || scl_f) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
      if (state_nxt != BUSY || start || stop) begin
        bit_valid <= 1'b0;
      end else if (state == BUSY && scl_rise) begin
        bit_valid <= 1'b1;
        bit_val   <= sda_f;
      end else if (scl_fall) begin
        bit_valid <= 1'b0;
      end
    end
  end

  assign bus_busy = (state == BUSY);

  smbus_evt_t mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;

  assign evt_valid = (count != '0);
  assign evt_code  = evt_valid ? mem[rptr] : EVT_NONE;
  assign pop       = evt_valid & evt_ready;
  assign full      = (count == FULL_CNT);
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= push_code;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ltpi_smbus_event_detector.sv
// Directed bench for the SMBus event detector.
// Drives bus sequences and checks the popped event stream.
module tb_ltpi_smbus_event_detector;
  import ltpi_smbus_pkg::*;

  localparam int H   = 8;
  localparam int TMO = 25000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic scl = 1'b1;
  logic sda = 1'b1;
  logic evt_ready = 1'b1;
  logic overflow_clr = 1'b0;
  logic evt_valid;
  logic bus_busy;
  logic timeout_pulse;
  logic overflow;
  smbus_evt_t evt_code;

  int n_cmp = 0;
  int n_err = 0;
  int tp_cnt = 0;
  logic [2:0] got_q [$];

  always #5 clk = ~clk;

  ltpi_smbus_event_detector dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .scl_i         (scl),
    .sda_i         (sda),
    .evt_valid     (evt_valid),
    .evt_code      (evt_code),
    .evt_ready     (evt_ready),
    .bus_busy      (bus_busy),
    .timeout_pulse (timeout_pulse),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  always begin
    @(negedge clk);
    #2;
    if (reset_n && evt_valid && evt_ready) got_q.push_back(evt_code);
    if (reset_n && timeout_pulse) tp_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic c, input logic d);
    @(negedge clk);
    scl = c;
    sda = d;
    wait_n(H);
  endtask

  task automatic do_start();
    drive(scl, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic do_bit(input logic b);
    drive(1'b0, b);
    drive(1'b1, b);
    drive(1'b0, b);
  endtask

  task automatic do_stop();
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
  endtask

  task automatic check_q(input string tag, input logic [2:0] exp [$]);
    wait_n(20);
    chk({tag, "_n"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got_q.size())
        chk($sformatf("%s_%0d", tag, i), got_q[i], exp[i]);
    end
    got_q.delete();
  endtask

  initial begin
    logic [7:0] byte_v;
    wait_n(3);
    reset_n = 1'b1;
    wait_n(2);
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, EVT_NONE);
    chk("rst_busy", bus_busy, 0);
    chk("rst_tmo", timeout_pulse, 0);
    chk("rst_ovf", overflow, 0);

    // write of 0xA5 with ACK
    byte_v = 8'hA5;
    do_start();
    chk("wr_busy1", bus_busy, 1);
    for (int i = 7; i >= 0; i--) do_bit(byte_v[i]);
    do_bit(1'b0);
    do_stop();
    wait_n(10);
    chk("wr_busy0", bus_busy, 0);
    check_q("wr", '{EVT_START, EVT_DATA1, EVT_DATA0, EVT_DATA1,
                    EVT_DATA0, EVT_DATA0, EVT_DATA1, EVT_DATA0,
                    EVT_DATA1, EVT_DATA0, EVT_STOP});

    // repeated start interrupts the fourth bit
    do_start();
    do_bit(1'b1);
    do_bit(1'b1);
    do_bit(1'b0);
    do_start();
    do_stop();
    check_q("rs", '{EVT_START, EVT_DATA1, EVT_DATA1, EVT_DATA0,
                    EVT_START, EVT_STOP});

    // short SDA glitch with SCL high
    @(negedge clk);
    sda = 1'b0;
    wait_n(2);
    sda = 1'b1;
    wait_n(20);
    chk("glitch_n", got_q.size(), 0);
    chk("glitch_busy", bus_busy, 0);

    // SCL stuck low after START
    tp_cnt = 0;
    do_start();
    chk("tmo_busy1", bus_busy, 1);
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge clk);
      if (tp_cnt != 0) break;
    end
    wait_n(5);
    chk("tmo_pulses", tp_cnt, 1);
    chk("tmo_busy0", bus_busy, 0);
    check_q("tmo", '{EVT_START, EVT_TIMEOUT});
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    wait_n(10);
    chk("tmo_rel_n", got_q.size(), 0);
    got_q.delete();

    // overflow: 10 events into 8 entries
    evt_ready = 1'b0;
    do_start();
    byte_v = 8'hB2;
    for (int i = 7; i >= 0; i--) do_bit(byte_v[i]);
    do_bit(1'b1);
    wait_n(5);
    chk("ovf_set", overflow, 1);
    chk("ovf_head_v", evt_valid, 1);
    chk("ovf_head", evt_code, EVT_START);
    @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    #1;
    chk("ovf_clr", overflow, 0);
    evt_ready = 1'b1;
    check_q("ovf", '{EVT_START, EVT_DATA1, EVT_DATA0, EVT_DATA1,
                     EVT_DATA1, EVT_DATA0, EVT_DATA0, EVT_DATA1});
    do_stop();
    check_q("ovf_stop", '{EVT_STOP});

    // reset mid-byte with 3 events queued
    evt_ready = 1'b0;
    do_start();
    do_bit(1'b1);
    do_bit(1'b0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    chk("mid_valid", evt_valid, 1);
    chk("mid_busy", bus_busy, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_busy", bus_busy, 0);
    chk("mid_rst_code", evt_code, EVT_NONE);
    wait_n(2);
    reset_n = 1'b1;
    evt_ready = 1'b1;
    got_q.delete();

    // traffic resumes: nothing until the next START
    drive(1'b0, 1'b1);
    do_bit(1'b0);
    do_bit(1'b1);
    wait_n(10);
    chk("resume_n", got_q.size(), 0);
    chk("resume_busy", bus_busy, 0);
    do_start();
    do_bit(1'b1);
    do_stop();
    check_q("resume", '{EVT_START, EVT_DATA1, EVT_STOP});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
